uart_receiver: RTL and testbench
================================

# uart_receiver

Serial-to-parallel UART receive stage that consumes the single-wire output of the team's `uart_transmitter`. It consumes 8N1 frames: 1 start bit (0), 8 data bits LSB first, and 1 stop bit (1). The line idles high. Each completed byte is presented on a parallel bus with a one-cycle valid pulse. The block sits directly downstream of the transmitter and is used both as its loopback checker and as the system receive path.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit. Legal range is ≥ 4 and must match the transmitter's bit period.
- `clk`  input  1  single system clock. Rising-edge.
- `rst`  input  1  asynchronous, active-low reset (0 = reset).
- `rx`  input  1  serial line, asynchronous to `clk`. Idle = 1.
- `data`  output  8  last correctly received byte. Held until the next good frame.
- `valid`  output  1  one-cycle pulse: `data` was updated this cycle.
- `frame_err`  output  1  one-cycle pulse: stop bit sampled as 0.
- `busy`  output  1  high while a frame is being received (any state other than IDLE).

## Operation
- `rx` passes through a 2-flop synchronizer, reset value 1, to produce `rx_s`. All logic uses `rx_s` only.
- State machine has five states: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE:
  - `busy` = 0.
  - `rx_s` == 0 → go to START, clear the bit-period counter.
- START:
  - Count to `CLKS_PER_BIT/2` (integer division) to reach mid-bit.
  - At mid-bit, `rx_s` == 0 → go to DATA, clear the counter and bit index.
  - At mid-bit, `rx_s` == 1 → false start: return to IDLE. No output pulse.
- DATA:
  - Every `CLKS_PER_BIT` cycles, sample `rx_s` into shift register bit `[idx]`. Bit 0 arrives first.
  - After bit 7 → go to STOP.
- STOP:
  - After `CLKS_PER_BIT` cycles, sample `rx_s`.
  - Sample 1 → load `data` from the shift register, pulse `valid`, go to IDLE.
  - Sample 0 → pulse `frame_err`, leave `data` unchanged, go to WAIT_IDLE.
- WAIT_IDLE:
  - Stay until `rx_s` == 1, then go to IDLE. This prevents a break condition (line held low) from being decoded as repeated frames.
- Counters:
  - Bit counter width is `$clog2(CLKS_PER_BIT)` and it is compared against `CLKS_PER_BIT-1`. It must not wrap silently.
  - Index counter is 3 bits.
- `valid` and `frame_err` are never high in the same cycle.
- Back-to-back frames: a start edge seen in the cycle after STOP→IDLE is accepted. No extra idle time is required beyond the stop bit.

## Timing
- Reset values (`rst` = 0, asynchronous):
  - state = IDLE.
  - `data` = 8'h00.
  - `valid` = 0, `frame_err` = 0, `busy` = 0.
  - Synchronizer flops = 1.
  - Counters = 0.
- Reset asserted mid-frame aborts immediately. No pulse is emitted, and after release the block waits in IDLE for a new falling edge.
- Synchronizer latency: 2 cycles from `rx` to `rx_s`.
- Define T0 as the first rising edge where IDLE sees `rx_s` == 0.
- Mid-start sample: T0 + `CLKS_PER_BIT/2`.
- Data bit i (0..7) sample: T0 + `CLKS_PER_BIT/2` + (i+1)·`CLKS_PER_BIT`.
- Stop sample: T0 + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT`. `valid` or `frame_err` is registered and high for exactly the one following cycle.
- `busy` rises the cycle after T0. It falls the same cycle `valid` rises, or the cycle after WAIT_IDLE exits.
- `data` changes only on the cycle `valid` is high.

## Test plan
- **Good byte:** `CLKS_PER_BIT` = 4, transmit 8'hA5 as 8N1 → one `valid` pulse, `data` = 8'hA5, `frame_err` stays 0, `busy` low afterwards.
- **Loopback:** drive `uart_transmitter` with 8'b10101010 and feed its `out` to `rx` (matched bit period) → `valid` once, `data` = 8'hAA.
- **Back-to-back:** frames 8'h00, 8'hFF, 8'h3C with no idle gap → three `valid` pulses in order with those values, each exactly 10·`CLKS_PER_BIT` cycles apart.
- **Glitch:** `rx` low for 1 cycle (shorter than `CLKS_PER_BIT/2`) → no `valid`, no `frame_err`; `busy` pulses, then the block returns to IDLE.
- **Framing error / break:** frame with stop bit 0, then `rx` held low for 40 bit times → exactly one `frame_err`, `data` retains its previous value, no new frame decoded until `rx` returns high and a fresh start bit arrives.
- **Reset mid-frame:** assert `rst` = 0 during bit 4 of 8'h5A, release, then send 8'h81 → all outputs at reset values during reset, no pulse for the aborted frame, then `valid` with `data` = 8'h81.

Source files
------------

// File: rtl/uart_receiver.sv
// 8N1 UART receive stage: synchronizes rx, finds mid-bit sample points and
// presents each good byte with a one-cycle valid pulse.
module uart_receiver #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_e;

  state_e        state_q, state_d;
  logic          rx_meta_q, rx_meta_d;
  logic          rx_s_q, rx_s_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          frame_err_q, frame_err_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_meta_q   <= rx_meta_d;
      rx_s_q      <= rx_s_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    rx_meta_d   = rx;
    rx_s_d      = rx_meta_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end

      // A start bit that is high again at mid-bit is treated as a glitch.
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            state_d = S_DATA;
            idx_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s_q;
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // Hold off until the line is released so a break is not re-decoded.
      S_WAIT_IDLE: begin
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: builds a per-cycle rx/rst waveform, derives
// expected outputs from the frame timing rules, and compares every cycle.
module tb_uart_receiver;

  localparam int CPB = 4;
  localparam int H   = CPB / 2;
  localparam int N   = 1024;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .data     (data),
    .valid    (valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // line_a[n]/rst_a[n]: values driven just after rising edge n.
  logic       line_a    [N];
  logic       rst_a     [N];
  logic       exp_valid [N];
  logic       exp_ferr  [N];
  logic       exp_busy  [N];
  logic [7:0] exp_data  [N];
  logic [7:0] cap_byte  [N];

  int wp;
  int total;
  int bad;

  int         m_vcyc[$];
  logic [7:0] m_vdata[$];
  int         m_ferr_n;
  int         d_vcyc[$];
  logic [7:0] d_vdata[$];
  logic [7:0] d_fdata[$];

  task automatic put(input logic v, input int n, input logic r);
    for (int i = 0; i < n; i++) begin
      line_a[wp] = v;
      rst_a[wp]  = r;
      wp++;
    end
  endtask

  task automatic put_frame(input logic [7:0] b, input logic stop);
    put(1'b0, CPB, 1'b1);
    for (int i = 0; i < 8; i++) put(b[i], CPB, 1'b1);
    put(stop, CPB, 1'b1);
  endtask

  task automatic chk(input string name, input int n, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, n, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // True when rising edge e occurs while reset is held.
  function automatic bit rst_at_edge(input int e);
    if (e <= 0) return 1'b1;
    if (e > N) return 1'b0;
    return rst_a[e-1] == 1'b0;
  endfunction

  // Synchronized line value the receiver acts on at rising edge e.
  function automatic logic rs(input int e);
    if (e < 3 || e > N) return 1'b1;
    if (!rst_a[e-1] || !rst_a[e-2] || !rst_a[e-3]) return 1'b1;
    return line_a[e-3];
  endfunction

  function automatic int first_reset(input int a, input int b);
    for (int e = a; e <= b; e++) if (rst_at_edge(e)) return e;
    return -1;
  endfunction

  task automatic mark_busy(input int a, input int b);
    for (int c = a; c <= b; c++) if (c >= 0 && c < N) exp_busy[c] = 1'b1;
  endtask

  // Frame-level model: T0, mid-start, data and stop sample edges from timing rules.
  task automatic build_model();
    int e, t0, ms, s, w, r;
    logic [7:0] sh;
    logic [7:0] d;
    for (int c = 0; c < N; c++) begin
      exp_valid[c] = 1'b0;
      exp_ferr[c]  = 1'b0;
      exp_busy[c]  = 1'b0;
      cap_byte[c]  = 8'h00;
    end
    m_ferr_n = 0;
    e = 0;
    while (e < N) begin
      if (rst_at_edge(e) || rs(e)) begin
        e++;
        continue;
      end
      t0 = e;
      ms = t0 + H;
      r  = first_reset(t0 + 1, ms);
      if (r >= 0) begin mark_busy(t0, r - 1); e = r; continue; end
      if (rs(ms)) begin mark_busy(t0, ms - 1); e = ms + 1; continue; end
      s = ms + 9 * CPB;
      r = first_reset(ms + 1, s);
      if (r >= 0) begin mark_busy(t0, r - 1); e = r; continue; end
      for (int i = 0; i < 8; i++) sh[i] = rs(ms + (i + 1) * CPB);
      mark_busy(t0, s - 1);
      if (rs(s)) begin
        if (s < N) begin
          exp_valid[s] = 1'b1;
          cap_byte[s]  = sh;
        end
        m_vcyc.push_back(s);
        m_vdata.push_back(sh);
        e = s + 1;
      end else begin
        if (s < N) exp_ferr[s] = 1'b1;
        m_ferr_n++;
        w = s + 1;
        while (w < N && !rst_at_edge(w) && !rs(w)) w++;
        mark_busy(s, w - 1);
        e = rst_at_edge(w) ? w : w + 1;
      end
    end
    d = 8'h00;
    for (int c = 0; c < N; c++) begin
      if (!rst_a[c]) begin
        exp_busy[c]  = 1'b0;
        exp_valid[c] = 1'b0;
        exp_ferr[c]  = 1'b0;
      end
      if (!rst_a[c] || rst_at_edge(c)) d = 8'h00;
      else if (exp_valid[c]) d = cap_byte[c];
      exp_data[c] = d;
    end
  endtask

  initial begin
    logic [7:0] lit [7];
    int p;
    lit = '{8'hA5, 8'hAA, 8'h00, 8'hFF, 8'h3C, 8'h96, 8'h81};
    rst   = 1'b0;
    rx    = 1'b1;
    total = 0;
    bad   = 0;
    wp    = 0;
    for (int c = 0; c < N; c++) begin
      line_a[c] = 1'b1;
      rst_a[c]  = 1'b1;
    end

    put(1'b1, 4, 1'b0);
    put(1'b1, 10, 1'b1);
    put_frame(8'hA5, 1'b1);
    put(1'b1, 8, 1'b1);
    put_frame(8'hAA, 1'b1);
    put(1'b1, 8, 1'b1);
    put_frame(8'h00, 1'b1);
    put_frame(8'hFF, 1'b1);
    put_frame(8'h3C, 1'b1);
    put(1'b1, 8, 1'b1);
    put(1'b0, 1, 1'b1);
    put(1'b1, 10, 1'b1);
    put_frame(8'h77, 1'b0);
    put(1'b0, 40 * CPB, 1'b1);
    put(1'b1, 10, 1'b1);
    put_frame(8'h96, 1'b1);
    put(1'b1, 12, 1'b1);
    p = wp;
    put_frame(8'h5A, 1'b1);
    // Reset from inside data bit 4 until the aborted frame has fully passed.
    for (int c = p + 5 * CPB + 1; c < p + 10 * CPB + 6; c++) rst_a[c] = 1'b0;
    put(1'b1, 10, 1'b1);
    put_frame(8'h81, 1'b1);
    put(1'b1, 20, 1'b1);

    build_model();

    chk_int("model_valid_count", m_vcyc.size(), 7);
    chk_int("model_first_valid_cycle", (m_vcyc.size() > 0) ? m_vcyc[0] : -1, 55);
    chk_int("model_ferr_count", m_ferr_n, 1);
    for (int i = 0; i < 7; i++)
      chk("model_byte", i, (i < m_vdata.size()) ? m_vdata[i] : 8'hxx, lit[i]);

    for (int n = 0; n < wp + 8; n++) begin
      @(posedge clk);
      #1;
      rx  = line_a[n];
      rst = rst_a[n];
      @(negedge clk);
      chk("valid", n, {7'd0, valid}, {7'd0, exp_valid[n]});
      chk("frame_err", n, {7'd0, frame_err}, {7'd0, exp_ferr[n]});
      chk("busy", n, {7'd0, busy}, {7'd0, exp_busy[n]});
      chk("data", n, data, exp_data[n]);
      if (valid === 1'b1) begin
        d_vcyc.push_back(n);
        d_vdata.push_back(data);
      end
      if (frame_err === 1'b1) d_fdata.push_back(data);
    end

    chk_int("dut_valid_count", d_vcyc.size(), 7);
    for (int i = 0; i < 7; i++)
      chk("dut_byte", i, (i < d_vdata.size()) ? d_vdata[i] : 8'hxx, lit[i]);
    chk_int("dut_first_valid_cycle", (d_vcyc.size() > 0) ? d_vcyc[0] : -1, 55);
    chk_int("b2b_gap_1", (d_vcyc.size() > 3) ? d_vcyc[3] - d_vcyc[2] : -1, 10 * CPB);
    chk_int("b2b_gap_2", (d_vcyc.size() > 4) ? d_vcyc[4] - d_vcyc[3] : -1, 10 * CPB);
    chk_int("dut_ferr_count", d_fdata.size(), 1);
    chk("data_kept_on_ferr", 0, (d_fdata.size() > 0) ? d_fdata[0] : 8'hxx, 8'h3C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
